// File: rtl/sump_host_ctrl_if.sv
// Request, UART byte and result signals between the SUMP host controller and its neighbours.
// The controller uses the slave view; the harness or bridge driving it uses the master view.
interface sump_host_ctrl_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [7:0]  CMD_OP;
  logic [31:0] CMD_ARG;
  logic [7:0]  TXB_DATA;
  logic        TXB_VALID;
  logic        TXB_READY;
  logic [7:0]  RXB_DATA;
  logic        RXB_VALID;
  logic [7:0]  SMP_DATA;
  logic        SMP_VALID;
  logic [31:0] META_DEPTH;
  logic [31:0] META_RATE;
  logic [7:0]  META_NCH;
  logic [7:0]  META_PROTO;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ARG, TXB_READY, RXB_DATA, RXB_VALID,
    output CMD_READY, TXB_DATA, TXB_VALID, SMP_DATA, SMP_VALID,
           META_DEPTH, META_RATE, META_NCH, META_PROTO, BUSY, DONE, ERR
  );

  modport master (
    output CMD_VALID, CMD_OP, CMD_ARG, TXB_READY, RXB_DATA, RXB_VALID,
    input  CMD_READY, TXB_DATA, TXB_VALID, SMP_DATA, SMP_VALID,
           META_DEPTH, META_RATE, META_NCH, META_PROTO, BUSY, DONE, ERR
  );
endinterface

// File: rtl/sump_host_ctrl.sv
// SUMP/OLS initiator: serialises requests to UART bytes, then collects the sample
// stream (arm) or parses the metadata report (ID). Every output is registered.
module sump_host_ctrl #(
  parameter int DEPTH   = 8192,
  parameter int TIMEOUT = 48_000_000
) (
  input  logic            CAP_CLK,
  input  logic            RST,
  sump_host_ctrl_if.slave bus
);

  localparam int SCW = $clog2(DEPTH) + 1;
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam logic [SCW-1:0] DEPTH_M1 = SCW'(DEPTH - 1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, RESP_SMP, RESP_ID} state_t;
  typedef enum logic [1:0] {TAG, STR, NUM} id_state_t;

  // Opcodes 0x00..0x02 carry no argument bytes.
  function automatic logic is_short_op(input logic [7:0] op);
    return (op <= 8'h02);
  endfunction

  function automatic logic [7:0] arg_byte(input logic [31:0] arg, input logic [2:0] idx);
    case (idx)
      3'd0:    return arg[7:0];
      3'd1:    return arg[15:8];
      3'd2:    return arg[23:16];
      3'd3:    return arg[31:24];
      default: return 8'h00;
    endcase
  endfunction

  state_t      state_r, state_nx_s;
  id_state_t   id_r, id_nx_s;
  logic [7:0]  op_r, op_nx_s;
  logic [31:0] arg_r, arg_nx_s;
  logic [2:0]  idx_r, idx_nx_s;
  logic        txb_valid_r, txb_valid_nx_s;
  logic [7:0]  txb_data_r, txb_data_nx_s;
  logic        smp_valid_r, smp_valid_nx_s;
  logic [7:0]  smp_data_r, smp_data_nx_s;
  logic        done_r, done_nx_s;
  logic        err_r, err_nx_s;
  logic        cmd_ready_r, busy_r;
  logic [31:0] meta_depth_r, meta_depth_nx_s;
  logic [31:0] meta_rate_r, meta_rate_nx_s;
  logic [7:0]  meta_nch_r, meta_nch_nx_s;
  logic [7:0]  meta_proto_r, meta_proto_nx_s;
  logic [SCW-1:0] smp_cnt_r, smp_cnt_nx_s;
  logic [TOW-1:0] to_cnt_r, to_cnt_nx_s;
  logic [TOW-1:0] to_inc_s;
  logic [31:0] acc_r, acc_nx_s, acc_shift_s;
  logic [1:0]  num_left_r, num_left_nx_s;
  logic [7:0]  tag_r, tag_nx_s;
  logic [2:0]  last_idx_s;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_nx_s      = state_r;
    id_nx_s         = id_r;
    op_nx_s         = op_r;
    arg_nx_s        = arg_r;
    idx_nx_s        = idx_r;
    txb_valid_nx_s  = txb_valid_r;
    txb_data_nx_s   = txb_data_r;
    smp_valid_nx_s  = 1'b0;
    smp_data_nx_s   = smp_data_r;
    done_nx_s       = 1'b0;
    err_nx_s        = 1'b0;
    meta_depth_nx_s = meta_depth_r;
    meta_rate_nx_s  = meta_rate_r;
    meta_nch_nx_s   = meta_nch_r;
    meta_proto_nx_s = meta_proto_r;
    smp_cnt_nx_s    = smp_cnt_r;
    to_cnt_nx_s     = to_cnt_r;
    acc_nx_s        = acc_r;
    num_left_nx_s   = num_left_r;
    tag_nx_s        = tag_r;
    last_idx_s      = is_short_op(op_r) ? 3'd0 : 3'd4;
    to_inc_s        = bus.RXB_VALID ? {TOW{1'b0}} : (to_cnt_r + {{(TOW-1){1'b0}}, 1'b1});
    acc_shift_s     = {acc_r[23:0], bus.RXB_DATA};

    case (state_r)
      IDLE: begin
        if (bus.CMD_VALID) begin
          op_nx_s        = bus.CMD_OP;
          arg_nx_s       = bus.CMD_ARG;
          idx_nx_s       = 3'd0;
          txb_valid_nx_s = 1'b1;
          txb_data_nx_s  = bus.CMD_OP;
          state_nx_s     = SEND;
        end else begin
          to_cnt_nx_s = {TOW{1'b0}};
        end
      end

      SEND: begin
        if (txb_valid_r && bus.TXB_READY) begin
          if (idx_r == last_idx_s) begin
            txb_valid_nx_s = 1'b0;
            to_cnt_nx_s    = {TOW{1'b0}};
            case (op_r)
              8'h01: begin
                state_nx_s   = RESP_SMP;
                smp_cnt_nx_s = {SCW{1'b0}};
              end
              8'h02: begin
                state_nx_s = RESP_ID;
                id_nx_s    = TAG;
              end
              default: begin
                state_nx_s = IDLE;
                done_nx_s  = 1'b1;
              end
            endcase
          end else begin
            idx_nx_s      = idx_r + 3'd1;
            txb_data_nx_s = arg_byte(arg_r, idx_r);
          end
        end else begin
          txb_valid_nx_s = txb_valid_r;
        end
      end

      RESP_SMP: begin
        to_cnt_nx_s = to_inc_s;
        if (bus.RXB_VALID) begin
          smp_valid_nx_s = 1'b1;
          smp_data_nx_s  = bus.RXB_DATA;
          if (smp_cnt_r == DEPTH_M1) begin
            done_nx_s  = 1'b1;
            state_nx_s = IDLE;
          end else begin
            smp_cnt_nx_s = smp_cnt_r + {{(SCW-1){1'b0}}, 1'b1};
          end
        end else if (to_inc_s == TO_LAST) begin
          err_nx_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          smp_valid_nx_s = 1'b0;
        end
      end

      RESP_ID: begin
        to_cnt_nx_s = to_inc_s;
        if (bus.RXB_VALID) begin
          case (id_r)
            TAG: begin
              tag_nx_s = bus.RXB_DATA;
              acc_nx_s = 32'h0000_0000;
              case (bus.RXB_DATA)
                8'h00: begin
                  done_nx_s  = 1'b1;
                  state_nx_s = IDLE;
                end
                8'h01, 8'h02: id_nx_s = STR;
                8'h21, 8'h23: begin
                  id_nx_s       = NUM;
                  num_left_nx_s = 2'd3;
                end
                8'h40, 8'h41: begin
                  id_nx_s       = NUM;
                  num_left_nx_s = 2'd0;
                end
                default: begin
                  err_nx_s   = 1'b1;
                  state_nx_s = IDLE;
                end
              endcase
            end
            STR: begin
              if (bus.RXB_DATA == 8'h00) begin
                id_nx_s = TAG;
              end else begin
                id_nx_s = STR;
              end
            end
            NUM: begin
              acc_nx_s = acc_shift_s;
              if (num_left_r == 2'd0) begin
                id_nx_s = TAG;
                // Only a completed field reaches the metadata registers.
                case (tag_r)
                  8'h21:   meta_depth_nx_s = acc_shift_s;
                  8'h23:   meta_rate_nx_s  = acc_shift_s;
                  8'h40:   meta_nch_nx_s   = acc_shift_s[7:0];
                  8'h41:   meta_proto_nx_s = acc_shift_s[7:0];
                  default: meta_nch_nx_s   = meta_nch_r;
                endcase
              end else begin
                num_left_nx_s = num_left_r - 2'd1;
              end
            end
            default: id_nx_s = TAG;
          endcase
        end else if (to_inc_s == TO_LAST) begin
          err_nx_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          id_nx_s = id_r;
        end
      end

      default: state_nx_s = IDLE;
    endcase
  end

  // State and output register bank; reset drops every output asynchronously.
  always_ff @(posedge CAP_CLK or posedge RST) begin
    if (RST) begin
      state_r      <= IDLE;
      id_r         <= TAG;
      op_r         <= 8'h00;
      arg_r        <= 32'h0000_0000;
      idx_r        <= 3'd0;
      txb_valid_r  <= 1'b0;
      txb_data_r   <= 8'h00;
      smp_valid_r  <= 1'b0;
      smp_data_r   <= 8'h00;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cmd_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      meta_depth_r <= 32'h0000_0000;
      meta_rate_r  <= 32'h0000_0000;
      meta_nch_r   <= 8'h00;
      meta_proto_r <= 8'h00;
      smp_cnt_r    <= {SCW{1'b0}};
      to_cnt_r     <= {TOW{1'b0}};
      acc_r        <= 32'h0000_0000;
      num_left_r   <= 2'd0;
      tag_r        <= 8'h00;
    end else begin
      state_r      <= state_nx_s;
      id_r         <= id_nx_s;
      op_r         <= op_nx_s;
      arg_r        <= arg_nx_s;
      idx_r        <= idx_nx_s;
      txb_valid_r  <= txb_valid_nx_s;
      txb_data_r   <= txb_data_nx_s;
      smp_valid_r  <= smp_valid_nx_s;
      smp_data_r   <= smp_data_nx_s;
      done_r       <= done_nx_s;
      err_r        <= err_nx_s;
      cmd_ready_r  <= (state_nx_s == IDLE);
      busy_r       <= (state_nx_s != IDLE);
      meta_depth_r <= meta_depth_nx_s;
      meta_rate_r  <= meta_rate_nx_s;
      meta_nch_r   <= meta_nch_nx_s;
      meta_proto_r <= meta_proto_nx_s;
      smp_cnt_r    <= smp_cnt_nx_s;
      to_cnt_r     <= to_cnt_nx_s;
      acc_r        <= acc_nx_s;
      num_left_r   <= num_left_nx_s;
      tag_r        <= tag_nx_s;
    end
  end

  assign bus.CMD_READY  = cmd_ready_r;
  assign bus.TXB_DATA   = txb_data_r;
  assign bus.TXB_VALID  = txb_valid_r;
  assign bus.SMP_DATA   = smp_data_r;
  assign bus.SMP_VALID  = smp_valid_r;
  assign bus.META_DEPTH = meta_depth_r;
  assign bus.META_RATE  = meta_rate_r;
  assign bus.META_NCH   = meta_nch_r;
  assign bus.META_PROTO = meta_proto_r;
  assign bus.BUSY       = busy_r;
  assign bus.DONE       = done_r;
  assign bus.ERR        = err_r;

endmodule

// File: tb/tb_sump_host_ctrl.sv
// Directed bench for sump_host_ctrl: byte and sample scoreboards filled as stimulus
// is driven and drained as the controller produces TXB handshakes and SMP strobes.
module tb_sump_host_ctrl;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sump_host_ctrl_if bus ();

  sump_host_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CAP_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  int n_asserts = 0;
  int n_fails   = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, smp_cnt = 0;
  int last_done_cyc = 0, last_hs_cyc = 0, last_smp_cyc = 0;
  logic [7:0] tx_q[$];
  logic [7:0] smp_q[$];
  bit expect_smp = 1'b0;
  bit hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes before the edge, strobes after it.
  task automatic tick();
    logic [7:0] exp_b;
    if (hold_pending) begin
      chk("tx_hold_valid", {31'd0, bus.TXB_VALID}, 32'd1);
      chk("tx_hold_data", {24'd0, bus.TXB_DATA}, {24'd0, hold_data});
    end
    hold_pending = (bus.TXB_VALID === 1'b1) && (bus.TXB_READY === 1'b0);
    hold_data    = bus.TXB_DATA;
    if (bus.TXB_VALID === 1'b1 && bus.TXB_READY === 1'b1) begin
      exp_b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
      chk("tx_byte", {24'd0, bus.TXB_DATA}, {24'd0, exp_b});
      last_hs_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.SMP_VALID === 1'b1) begin
      exp_b = (smp_q.size() != 0) ? smp_q.pop_front() : 8'hxx;
      chk("smp_data", {24'd0, bus.SMP_DATA}, {24'd0, exp_b});
      smp_cnt++;
      last_smp_cyc = cyc;
    end
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.ERR === 1'b1) err_cnt++;
    if (bus.DONE === 1'b1 || bus.ERR === 1'b1)
      chk("done_err_excl", {31'd0, bus.DONE & bus.ERR}, 32'd0);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg);
    tx_q.push_back(op);
    if (op > 8'h02) begin
      tx_q.push_back(arg[7:0]);
      tx_q.push_back(arg[15:8]);
      tx_q.push_back(arg[23:16]);
      tx_q.push_back(arg[31:24]);
    end
    bus.CMD_OP    = op;
    bus.CMD_ARG   = arg;
    bus.CMD_VALID = 1'b1;
    chk("cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
    tick();
    bus.CMD_VALID = 1'b0;
    chk("txb_first_valid", {31'd0, bus.TXB_VALID}, 32'd1);
    chk("txb_first_data", {24'd0, bus.TXB_DATA}, {24'd0, op});
    chk("busy_send", {31'd0, bus.BUSY}, 32'd1);
  endtask

  task automatic drain_tx(input bit toggle);
    int b = 0;
    while (tx_q.size() != 0 && b < 200) begin
      bus.TXB_READY = toggle ? ((cyc % 4) == 3) : 1'b1;
      tick();
      b++;
    end
    chk("tx_drain", 32'(tx_q.size()), 32'd0);
    bus.TXB_READY = 1'b1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    bus.RXB_DATA  = b;
    bus.RXB_VALID = 1'b1;
    if (expect_smp) smp_q.push_back(b);
    tick();
    bus.RXB_VALID = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic rx_str(input string s);
    for (int i = 0; i < s.len(); i++) rx_byte(s[i], $urandom_range(0, 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, s0, c0, k;
    logic [31:0] md, mr;
    logic [7:0] mn, mp;

    rst = 1'b1;
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 8'h00; bus.CMD_ARG = 32'h0;
    bus.TXB_READY = 1'b1; bus.RXB_DATA = 8'h00; bus.RXB_VALID = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
    chk("rst_txb_valid", {31'd0, bus.TXB_VALID}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done_err", {30'd0, bus.DONE, bus.ERR}, 32'd0);
    chk("rst_meta", bus.META_DEPTH | bus.META_RATE | {24'd0, bus.META_NCH | bus.META_PROTO}, 32'd0);
    rst = 1'b0;
    tick();

    // 5-byte request with the transmitter always ready.
    d0 = done_cnt;
    send_cmd(8'h80, 32'h0000_0063);
    c0 = cyc;
    drain_tx(1'b0);
    chk("t1_consecutive", 32'(last_hs_cyc - c0), 32'd5);
    chk("t1_done_cycle", 32'(last_done_cyc), 32'(last_hs_cyc));
    tick();
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_low", {31'd0, bus.BUSY}, 32'd0);

    // Single-byte reset opcode with a stalling transmitter.
    d0 = done_cnt;
    send_cmd(8'h00, 32'h0);
    drain_tx(1'b1);
    repeat (3) tick();
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t2_busy_low", {31'd0, bus.BUSY}, 32'd0);

    // Metadata report.
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'h02, 32'h0);
    drain_tx(1'b0);
    chk("t3_busy_resp", {31'd0, bus.BUSY}, 32'd1);
    rx_byte(8'h01, 0); rx_str("iCECapture"); rx_byte(8'h00, 1);
    rx_byte(8'h02, 0); rx_str("0.1"); rx_byte(8'h00, 0);
    rx_byte(8'h21, 0); rx_byte(8'h00, 1); rx_byte(8'h00, 0); rx_byte(8'h20, 2); rx_byte(8'h00, 0);
    rx_byte(8'h23, 0); rx_byte(8'h02, 0); rx_byte(8'hDC, 1); rx_byte(8'h6C, 0); rx_byte(8'h00, 0);
    rx_byte(8'h40, 0); rx_byte(8'h08, 0); rx_byte(8'h41, 3); rx_byte(8'h02, 0);
    rx_byte(8'h00, 2);
    chk("t3_meta_depth", bus.META_DEPTH, 32'h0000_2000);
    chk("t3_meta_rate", bus.META_RATE, 32'h02DC_6C00);
    chk("t3_meta_nch", {24'd0, bus.META_NCH}, 32'd8);
    chk("t3_meta_proto", {24'd0, bus.META_PROTO}, 32'd2);
    chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t3_no_err", 32'(err_cnt - e0), 32'd0);
    chk("t3_busy_low", {31'd0, bus.BUSY}, 32'd0);

    // Full capture of DEPTH samples with random gaps.
    d0 = done_cnt; s0 = smp_cnt;
    expect_smp = 1'b1;
    send_cmd(8'h01, 32'h0);
    drain_tx(1'b0);
    for (int i = 0; i < DEPTH; i++) rx_byte(8'(i), $urandom_range(0, 4));
    expect_smp = 1'b0;
    chk("t4_smp_count", 32'(smp_cnt - s0), 32'(DEPTH));
    chk("t4_smp_q_empty", 32'(smp_q.size()), 32'd0);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t4_done_with_last", 32'(last_done_cyc), 32'(last_smp_cyc));
    chk("t4_busy_low", {31'd0, bus.BUSY}, 32'd0);
    rx_byte(8'hAA, 1); rx_byte(8'h55, 2);
    chk("t4_idle_rx_ignored", 32'(smp_cnt - s0), 32'(DEPTH));

    // Capture aborted by RX silence.
    e0 = err_cnt; s0 = smp_cnt;
    expect_smp = 1'b1;
    send_cmd(8'h01, 32'h0);
    drain_tx(1'b0);
    rx_byte(8'hA0, 0); rx_byte(8'hA1, 3);
    bus.RXB_DATA = 8'hA2; bus.RXB_VALID = 1'b1; smp_q.push_back(8'hA2);
    tick();
    bus.RXB_VALID = 1'b0;
    expect_smp = 1'b0;
    k = 1;
    while (bus.ERR !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk("t5_err_latency", 32'(k), 32'd100);
    chk("t5_smp_count", 32'(smp_cnt - s0), 32'd3);
    chk("t5_busy_low", {31'd0, bus.BUSY}, 32'd0);
    repeat (3) tick();
    chk("t5_err_once", 32'(err_cnt - e0), 32'd1);

    // Unknown metadata tag.
    e0 = err_cnt; d0 = done_cnt;
    md = bus.META_DEPTH; mr = bus.META_RATE; mn = bus.META_NCH; mp = bus.META_PROTO;
    send_cmd(8'h02, 32'h0);
    drain_tx(1'b0);
    rx_byte(8'h55, 2);
    chk("t6_err_once", 32'(err_cnt - e0), 32'd1);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_meta_depth", bus.META_DEPTH, md);
    chk("t6_meta_rate", bus.META_RATE, mr);
    chk("t6_meta_nch_proto", {16'd0, bus.META_NCH, bus.META_PROTO}, {16'd0, mn, mp});
    chk("t6_busy_low", {31'd0, bus.BUSY}, 32'd0);

    // Reset while the third command byte is pending.
    send_cmd(8'hC0, 32'h1122_3344);
    tick(); tick();
    bus.TXB_READY = 1'b0;
    chk("t7_third_byte", {24'd0, bus.TXB_DATA}, 32'h33);
    #2 rst = 1'b1;
    #1;
    chk("t7_txb_valid", {31'd0, bus.TXB_VALID}, 32'd0);
    chk("t7_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("t7_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
    chk("t7_meta_clear", bus.META_DEPTH | bus.META_RATE | {24'd0, bus.META_NCH | bus.META_PROTO}, 32'd0);
    tx_q.delete();
    hold_pending = 1'b0;
    bus.TXB_READY = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'h02, 32'h0);
    drain_tx(1'b0);
    rx_byte(8'h40, 0); rx_byte(8'h04, 1); rx_byte(8'h00, 2);
    chk("t7_meta_nch", {24'd0, bus.META_NCH}, 32'd4);
    chk("t7_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t7_no_err", 32'(err_cnt - e0), 32'd0);
    chk("t7_busy_low", {31'd0, bus.BUSY}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/sump_host_ctrl.md
Name: sump_host_ctrl

Overview:
- Initiator end of the SUMP/OLS serial protocol that the capture core answers.
- Serialises opcode/argument requests into UART byte transfers.
- Parses the device's response. An ID request yields a metadata report; an arm request yields the sample stream.
- Sits between the loopback/bring-up harness or bridge logic and a uart_tx/uart_rx pair on the same clock.

Parameters:
- DEPTH, 8192: sample bytes expected after an arm (0x01) request.
- TIMEOUT, 48_000_000: CAP_CLK cycles of RX silence tolerated in a response state before abort.

Ports:
- CAP_CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  request present
- CMD_READY  out  1  request accepted when VALID&&READY
- CMD_OP  in  8  SUMP opcode
- CMD_ARG  in  32  argument, sent LSB first for 5-byte opcodes
- TXB_DATA  out  8  byte to UART transmitter
- TXB_VALID  out  1  byte present; held with stable TXB_DATA until TXB_READY
- TXB_READY  in  1  transmitter accepts byte (the !tx_busy qualifier)
- RXB_DATA  in  8  byte from UART receiver
- RXB_VALID  in  1  one-cycle strobe, RXB_DATA valid
- SMP_DATA  out  8  received sample byte
- SMP_VALID  out  1  one-cycle strobe per sample
- META_DEPTH  out  32  last parsed tag 0x21 value
- META_RATE  out  32  last parsed tag 0x23 value
- META_NCH  out  8  last parsed tag 0x40 value
- META_PROTO  out  8  last parsed tag 0x41 value
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle strobe, transaction complete
- ERR  out  1  one-cycle strobe, transaction aborted

Behaviour:
- Reset state: IDLE. CMD_READY=1; all other outputs 0; META_* cleared to 0; all counters 0.
- Command length:
  - Opcodes 0x00, 0x01, 0x02 are 1 byte.
  - Every other opcode is 5 bytes: OP, then ARG[7:0], ARG[15:8], ARG[23:16], ARG[31:24].
- FSM states: IDLE, SEND, RESP_SMP, RESP_ID.
- IDLE:
  - CMD_READY=1 only here.
  - On accept at cycle N: latch OP/ARG, move to SEND. TXB_VALID=1 and TXB_DATA=OP at N+1.
  - RXB_VALID in IDLE is ignored.
- SEND:
  - Each VALID&&READY handshake advances the byte index. The next byte is presented the following cycle with no gap.
  - After the final byte's handshake, TXB_VALID drops and the next state depends on the opcode:
    - 0x01 goes to RESP_SMP.
    - 0x02 goes to RESP_ID.
    - Any other opcode returns to IDLE, with DONE pulsed the cycle after the final handshake.
  - RXB_VALID during SEND is ignored.
- RESP_SMP:
  - Each RXB_VALID produces SMP_VALID=1 and SMP_DATA=RXB_DATA one cycle later.
  - The count width is clog2(DEPTH)+1.
  - DONE is asserted in the same cycle as the DEPTH-th SMP_VALID, then the FSM returns to IDLE.
- RESP_ID is driven by a sub-FSM with states TAG, STR, NUM.
  - TAG state:
    - 0x00 pulses DONE next cycle and returns to IDLE.
    - 0x01 or 0x02 goes to STR. Bytes are discarded until 0x00, then back to TAG.
    - 0x21 or 0x23 goes to NUM with 4 bytes, MSB first.
    - 0x40 or 0x41 goes to NUM with 1 byte.
    - Any other tag pulses ERR and returns to IDLE; META_* are unchanged.
  - NUM state:
    - Bytes shift into a 32-bit accumulator.
    - On the last byte, the accumulator is written to the matching META register (8-bit tags take the low byte), then back to TAG.
    - META_* update only on a completed field; a partial field never updates.
- Timeout:
  - The counter clears on entry to RESP_SMP/RESP_ID and on every RXB_VALID.
  - Reaching TIMEOUT-1 pulses ERR and returns to IDLE.
  - No SMP_VALID is produced after an abort; samples already delivered stand.
- DONE and ERR are never asserted in the same cycle.
- RST asserted mid-transaction:
  - Immediate return to IDLE, all outputs as at reset.
  - Any partially sent command is abandoned; TXB_VALID drops asynchronously.

Test Plan:
- Reset, then request OP=0x80 ARG=0x00000063 with TXB_READY=1 -> TXB bytes 80,63,00,00,00 on consecutive cycles; DONE one cycle after last; BUSY low afterwards.
- Request OP=0x00 with TXB_READY toggling 1-in-4 -> single byte 00; TXB_DATA stable while VALID&&!READY; DONE pulses once.
- OP=0x02, then feed 01 'iCECapture' 00 02 '0.1' 00 21 00 00 20 00 23 02 DC 6C 00 40 08 41 02 00 -> META_DEPTH=0x00002000, META_RATE=0x02DC6C00, META_NCH=8, META_PROTO=2; DONE once, ERR never.
- DEPTH=16: OP=0x01, then feed 16 bytes 0x00..0x0F with random gaps -> 16 SMP_VALID pulses carrying 00..0F in order; DONE coincident with the 16th; extra RX bytes in IDLE produce nothing.
- TIMEOUT=100: OP=0x01, feed 3 bytes then silence -> 3 SMP_VALID; ERR exactly 100 cycles after the 3rd RXB_VALID; FSM returns to IDLE. OP=0x02 with first tag 0x55 -> ERR; META_* unchanged.
- Assert RST during the 3rd byte of a 0xC0 command -> TXB_VALID=0, BUSY=0, META_* cleared. A following OP=0x02 request completes normally.
